// File: rtl/input_buffer_ctrl_if.sv
// ============================================================================
// Module      : input_buffer_ctrl_if
// Description : Host byte stream, buffer lane and vector handshake bundle for
//               the NPU input buffer sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface input_buffer_ctrl_if;
  logic       START;
  logic       IN_VALID;
  logic [7:0] IN_DATA;
  logic       IN_READY;
  logic [7:0] DA;
  logic [7:0] DB;
  logic [7:0] DC;
  logic [7:0] DD;
  logic       EN_BUF_IN;
  logic       CLR_BUF_IN;
  logic       VEC_VALID;
  logic       VEC_ACK;
  logic [7:0] VEC_CNT;
  logic       BUSY;
  logic       DONE;

  modport master (
    output START, IN_VALID, IN_DATA, VEC_ACK,
    input  IN_READY, DA, DB, DC, DD, EN_BUF_IN, CLR_BUF_IN,
           VEC_VALID, VEC_CNT, BUSY, DONE
  );

  modport slave (
    input  START, IN_VALID, IN_DATA, VEC_ACK,
    output IN_READY, DA, DB, DC, DD, EN_BUF_IN, CLR_BUF_IN,
           VEC_VALID, VEC_CNT, BUSY, DONE
  );
endinterface

`default_nettype wire

// File: rtl/input_buffer_ctrl.sv
// ============================================================================
// Module      : input_buffer_ctrl
// Description : Packs host bytes into 4-lane vectors, loads the input buffer
//               and holds each vector valid until acknowledged downstream.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module input_buffer_ctrl #(
  parameter int NUM_VECTORS = 4
) (
  input  wire logic          CLKEXT,
  input  wire logic          RST,
  input_buffer_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_FILL     = 3'd2,
    S_LOAD     = 3'd3,
    S_WAIT_ACK = 3'd4,
    S_FINISH   = 3'd5
  } state_t;

  localparam logic [7:0] c_num_vec = 8'(NUM_VECTORS);

  state_t          state_q, state_d;
  logic [3:0][7:0] lane_q, lane_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      cnt_q, cnt_d;

  logic in_ready_q;
  logic en_buf_q;
  logic vec_valid_q;
  logic busy_q;
  logic done_q;
  logic clr_n_q;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.START) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        lane_d  = '0;
        idx_d   = '0;
        cnt_d   = '0;
        state_d = S_FILL;
      end
      S_FILL: begin
        if (bus.IN_VALID) begin
          lane_d[idx_q] = bus.IN_DATA;
          idx_d         = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (bus.VEC_ACK) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = (cnt_q + 8'd1 == c_num_vec) ? S_FINISH : S_FILL;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet
  // line up with the state they describe.
  always_ff @(posedge CLKEXT) begin
    if (RST) begin
      state_q     <= S_IDLE;
      lane_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      en_buf_q    <= 1'b0;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clr_n_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == S_FILL);
      en_buf_q    <= (state_d == S_LOAD);
      vec_valid_q <= (state_d == S_WAIT_ACK);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_FINISH);
      clr_n_q     <= (state_d != S_CLEAR);
    end
  end

  assign bus.IN_READY   = in_ready_q;
  assign bus.DA         = lane_q[0];
  assign bus.DB         = lane_q[1];
  assign bus.DC         = lane_q[2];
  assign bus.DD         = lane_q[3];
  assign bus.EN_BUF_IN  = en_buf_q;
  // The buffer is also held in clear for as long as system reset is high.
  assign bus.CLR_BUF_IN = clr_n_q & ~RST;
  assign bus.VEC_VALID  = vec_valid_q;
  assign bus.VEC_CNT    = cnt_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;

endmodule

`default_nettype wire
